// File: rtl/swt_led_ctrl_if.sv
// ----------------------------------------------------------------------------
// swt_led_ctrl_if
//   Bundles the board-facing and status signals of swt_led_ctrl.
//   swt        : raw switch inputs (asynchronous to the controller clock)
//   mode       : LED function select (0 pass, 1 invert, 2 toggle, 3 blink)
//   led        : registered LED drive
//   swt_db     : debounced switch levels
//   edge_pulse : one-cycle pulse per debounced rising transition
//   master modport drives swt/mode; slave modport is the controller side.
// ----------------------------------------------------------------------------
interface swt_led_ctrl_if #(
    parameter int N = 4
) ();
    logic [N-1:0] swt;
    logic [1:0]   mode;
    logic [N-1:0] led;
    logic [N-1:0] swt_db;
    logic [N-1:0] edge_pulse;

    modport master (
        output swt,
        output mode,
        input  led,
        input  swt_db,
        input  edge_pulse
    );

    modport slave (
        input  swt,
        input  mode,
        output led,
        output swt_db,
        output edge_pulse
    );
endinterface

// File: rtl/swt_led_ctrl.sv
// ----------------------------------------------------------------------------
// swt_led_ctrl
//   Switch-to-LED controller for N channels. Each raw switch is passed through
//   a two-flop synchroniser and a persistence-counter debouncer; each LED is a
//   registered function of its debounced switch selected by a global mode
//   (pass, invert, toggle-latch, blink).
// Ports
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset, clears every flop
//   bus  : swt_led_ctrl_if.slave (swt, mode in; led, swt_db, edge_pulse out)
// ----------------------------------------------------------------------------
module swt_led_ctrl #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic           clk,
    input  logic           rst,
    swt_led_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int PW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] BL_MAX = PW'(BLINK_DIV - 1);

    logic [N-1:0]         s1_q, s2_q;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]         db_q, db_d;
    logic [N-1:0]         ep_q, ep_d;
    logic [N-1:0]         tgl_q, tgl_d;
    logic [N-1:0]         led_q, led_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 blink_q, blink_d;

    // Debounce next state: a differing synchronised level must persist
    // DB_CYCLES edges before it is accepted; any reversion restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != DB_MAX) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = '0;
                db_d[i]  = s2_q[i];
            end
        end
        // Pulse is registered alongside swt_db so both appear in the same cycle.
        ep_d  = db_d & ~db_q;
        tgl_d = tgl_q ^ ep_d;
    end

    // Blink prescaler: phase inverts on each wrap, period 2*BLINK_DIV cycles.
    always_comb begin
        presc_d = presc_q;
        blink_d = blink_q;
        if (presc_q == BL_MAX) begin
            presc_d = '0;
            blink_d = ~blink_q;
        end else begin
            presc_d = presc_q + PW'(1);
            blink_d = blink_q;
        end
    end

    // LED function select from the currently registered sources.
    always_comb begin
        led_d = '0;
        case (bus.mode)
            2'd0:    led_d = db_q;
            2'd1:    led_d = ~db_q;
            2'd2:    led_d = tgl_q;
            2'd3:    led_d = db_q & {N{blink_q}};
            default: led_d = '0;
        endcase
    end

    // All state registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
            ep_q    <= '0;
            tgl_q   <= '0;
            led_q   <= '0;
            presc_q <= '0;
            blink_q <= 1'b0;
        end else begin
            s1_q    <= bus.swt;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            ep_q    <= ep_d;
            tgl_q   <= tgl_d;
            led_q   <= led_d;
            presc_q <= presc_d;
            blink_q <= blink_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.swt_db     = db_q;
    assign bus.edge_pulse = ep_q;
endmodule

// File: tb/tb_swt_led_ctrl.sv
// ----------------------------------------------------------------------------
// tb_swt_led_ctrl
//   Self-checking bench for swt_led_ctrl (N=4, DB_CYCLES=4, BLINK_DIV=3).
//   Each scenario pushes the expected {led, swt_db, edge_pulse} per edge into
//   a scoreboard queue and pops/compares one entry after every edge.
// ----------------------------------------------------------------------------
module tb_swt_led_ctrl;
    localparam int N = 4;

    typedef struct packed {
        logic [3:0] led;
        logic [3:0] db;
        logic [3:0] ep;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    exp_t exp_v;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    swt_led_ctrl_if #(.N(N)) bus ();

    swt_led_ctrl #(
        .N(N),
        .DB_CYCLES(4),
        .BLINK_DIV(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] l, input logic [3:0] d, input logic [3:0] e);
        exp_t x;
        x.led = l;
        x.db  = d;
        x.ep  = e;
        sb_q.push_back(x);
    endtask

    // Holds reset for two edges with the given mode, returns just after an edge
    // with rst released so the next edge is edge 1.
    task automatic apply_reset(input logic [1:0] m);
        rst      = 1'b1;
        bus.swt  = 4'h0;
        bus.mode = m;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.swt  = 4'hF;
        bus.mode = 2'd1;
        for (int k = 0; k < 3; k++) push(4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
        rst     = 1'b0;
        bus.swt = 4'h0;
        push(4'hF, 4'h0, 4'h0);
        push(4'hF, 4'h0, 4'h0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL reset_release edge %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
    endtask

    task automatic test_debounce();
        apply_reset(2'd0);
        for (int k = 1; k <= 9; k++)
            push((k >= 7) ? 4'h1 : 4'h0, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0);
        for (int k = 1; k <= 9; k++) begin
            bus.swt = 4'h1;
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL debounce edge %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset(2'd0);
        for (int k = 1; k <= 12; k++) push(4'h0, 4'h0, 4'h0);
        for (int k = 1; k <= 12; k++) begin
            bus.swt = (k <= 3) ? 4'h2 : 4'h0;
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL glitch edge %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
    endtask

    task automatic test_toggle();
        apply_reset(2'd2);
        for (int k = 1; k <= 40; k++)
            push((k >= 7 && k <= 26) ? 4'h4 : 4'h0,
                 ((k >= 6 && k < 16) || (k >= 26 && k < 36)) ? 4'h4 : 4'h0,
                 (k == 6 || k == 26) ? 4'h4 : 4'h0);
        for (int k = 1; k <= 40; k++) begin
            bus.swt = (k <= 10 || (k >= 21 && k <= 30)) ? 4'h4 : 4'h0;
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL toggle edge %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
    endtask

    task automatic test_blink();
        bit db_prev, bl_prev;
        apply_reset(2'd3);
        // Blink phase after edge k is 1 when (k/3) is odd; led uses edge k-1 sources.
        for (int k = 1; k <= 35; k++) begin
            db_prev = (k - 1 >= 6) && (k - 1 < 26);
            bl_prev = (((k - 1) / 3) % 2) == 1;
            push((db_prev && bl_prev) ? 4'h8 : 4'h0,
                 (k >= 6 && k < 26) ? 4'h8 : 4'h0,
                 (k == 6) ? 4'h8 : 4'h0);
        end
        for (int k = 1; k <= 35; k++) begin
            bus.swt = (k <= 20) ? 4'h8 : 4'h0;
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL blink edge %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(2'd1);
        bus.swt = 4'h1;
        for (int k = 1; k <= 4; k++) push(4'hF, 4'h0, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL async_pre edge %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
        // Counter now holds 2; assert rst between edges and look before any edge.
        #2;
        rst = 1'b1;
        #1;
        push(4'h0, 4'h0, 4'h0);
        exp_v = sb_q.pop_front();
        checks++;
        if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
            errors++;
            $display("FAIL async_assert: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                     bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            push((k >= 7) ? 4'hE : 4'hF, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({bus.led, bus.swt_db, bus.edge_pulse} !== exp_v) begin
                errors++;
                $display("FAIL async_post edge %0d: got led=%h db=%h ep=%h expected led=%h db=%h ep=%h",
                         k, bus.led, bus.swt_db, bus.edge_pulse, exp_v.led, exp_v.db, exp_v.ep);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        bus.swt  = 4'h0;
        bus.mode = 2'd0;
        test_reset();
        test_debounce();
        test_glitch();
        test_toggle();
        test_blink();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
